// File: rtl/divider_dividend_reconstructor.sv
// Rebuilds the dividend q*d + r of one divider transaction with a shift-add
// multiplier, reports |n - n_rec| and accumulates saturating error statistics.
module divider_dividend_reconstructor #(
  parameter int unsigned NW   = 16,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NW-1:0]   n,
  input  logic [DW-1:0]   d,
  input  logic [DW-1:0]   q,
  input  logic [DW-1:0]   r,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NW-1:0]   n_rec,
  output logic [NW-1:0]   abs_err,
  output logic            exact,
  output logic            div_by_zero,
  input  logic            clear,
  output logic [ACCW-1:0] err_sum,
  output logic [CNTW-1:0] sample_cnt
);

  localparam int unsigned BCW = (DW > 2) ? $clog2(DW) : 1;
  localparam int unsigned SW  = ((ACCW > NW) ? ACCW : NW) + 1;
  localparam logic [ACCW-1:0] ACC_MAX = '1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MUL, ERR, DONE} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic            dz_q, dz_d;
  logic [NW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [BCW-1:0]  bitcnt_q, bitcnt_d;
  logic [NW-1:0]   n_rec_q, n_rec_d;
  logic [NW-1:0]   abs_err_q, abs_err_d;
  logic            exact_q, exact_d;
  logic            dbz_q, dbz_d;
  logic [ACCW-1:0] err_sum_q, err_sum_d;
  logic [CNTW-1:0] sample_cnt_q, sample_cnt_d;
  logic            out_valid_q, out_valid_d;

  logic [NW-1:0]   abs_diff_c;
  logic [SW-1:0]   sum_wide_c;
  logic [ACCW-1:0] sum_sat_c;

  // Error of the finished product and its saturating contribution to err_sum
  assign abs_diff_c = (n_q >= acc_q) ? (n_q - acc_q) : (acc_q - n_q);
  assign sum_wide_c = SW'(err_sum_q) + SW'(abs_diff_c);
  assign sum_sat_c  = (sum_wide_c > SW'(ACC_MAX)) ? ACC_MAX : ACCW'(sum_wide_c);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    dz_d         = dz_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    bitcnt_d     = bitcnt_q;
    n_rec_d      = n_rec_q;
    abs_err_d    = abs_err_q;
    exact_d      = exact_q;
    dbz_d        = dbz_q;
    err_sum_d    = err_sum_q;
    sample_cnt_d = sample_cnt_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d      = n;
          dz_d     = (d == '0);
          acc_d    = NW'(r);
          mcand_d  = NW'(d);
          mplier_d = q;
          bitcnt_d = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bitcnt_d = bitcnt_q + BCW'(1);
        if (bitcnt_q == BCW'(DW - 1)) state_d = ERR;
      end
      ERR: begin
        n_rec_d     = acc_q;
        abs_err_d   = abs_diff_c;
        exact_d     = (abs_diff_c == '0);
        dbz_d       = dz_q;
        // A zero divisor yields no meaningful quotient, so it is kept out of the stats
        if (!dz_q) begin
          err_sum_d    = sum_sat_c;
          sample_cnt_d = (sample_cnt_q == CNT_MAX) ? CNT_MAX : sample_cnt_q + CNTW'(1);
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      err_sum_d    = '0;
      sample_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      dz_q         <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      bitcnt_q     <= '0;
      n_rec_q      <= '0;
      abs_err_q    <= '0;
      exact_q      <= 1'b0;
      dbz_q        <= 1'b0;
      err_sum_q    <= '0;
      sample_cnt_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      dz_q         <= dz_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      bitcnt_q     <= bitcnt_d;
      n_rec_q      <= n_rec_d;
      abs_err_q    <= abs_err_d;
      exact_q      <= exact_d;
      dbz_q        <= dbz_d;
      err_sum_q    <= err_sum_d;
      sample_cnt_q <= sample_cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Ready is a state decode gated by reset so it is low while rst_n is held
  assign in_ready    = rst_n && (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign n_rec       = n_rec_q;
  assign abs_err     = abs_err_q;
  assign exact       = exact_q;
  assign div_by_zero = dbz_q;
  assign err_sum     = err_sum_q;
  assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_divider_dividend_reconstructor.sv
// Scoreboard bench for divider_dividend_reconstructor: directed tuples with
// hand-computed results, plus an 8-bit accumulator instance for saturation.
module tb_divider_dividend_reconstructor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, clear;
  logic [15:0] n;
  logic [7:0]  d, q, r;

  logic        in_ready, out_valid, exact, div_by_zero;
  logic [15:0] n_rec, abs_err, sample_cnt;
  logic [31:0] err_sum;

  logic        in_ready8, out_valid8, exact8, dbz8;
  logic [15:0] n_rec8, abs_err8, cnt8;
  logic [7:0]  err8;

  divider_dividend_reconstructor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .n_rec(n_rec), .abs_err(abs_err), .exact(exact), .div_by_zero(div_by_zero),
    .clear(clear), .err_sum(err_sum), .sample_cnt(sample_cnt)
  );

  divider_dividend_reconstructor #(.ACCW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid8), .out_ready(out_ready),
    .n_rec(n_rec8), .abs_err(abs_err8), .exact(exact8), .div_by_zero(dbz8),
    .clear(clear), .err_sum(err8), .sample_cnt(cnt8)
  );

  typedef struct packed {
    logic [15:0] n_rec;
    logic [15:0] abs_err;
    logic        exact;
    logic        dbz;
    logic [31:0] err_sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rec, input logic [15:0] err, input logic ex,
                              input logic dz, input logic [31:0] sum, input logic [15:0] cnt);
    exp_t e;
    e.n_rec = rec; e.abs_err = err; e.exact = ex; e.dbz = dz; e.err_sum = sum; e.cnt = cnt;
    return e;
  endfunction

  // Monitor: compare every delivered result against the oldest expectation
  exp_t got;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got n_rec=%0d with no pending result expected", n_rec);
      end else begin
        got = sb.pop_front();
        check("n_rec", 32'(n_rec), 32'(got.n_rec));
        check("abs_err", 32'(abs_err), 32'(got.abs_err));
        check("exact", 32'(exact), 32'(got.exact));
        check("div_by_zero", 32'(div_by_zero), 32'(got.dbz));
        check("err_sum", err_sum, got.err_sum);
        check("sample_cnt", 32'(sample_cnt), 32'(got.cnt));
      end
    end
  end

  task automatic do_txn(input logic [15:0] tn, input logic [7:0] td, input logic [7:0] tq,
                        input logic [7:0] tr, input exp_t e, input int hold, input bit clr_err);
    int k;
    int lat;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    sb.push_back(e);
    n = tn; d = td; q = tq; r = tr; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 16'hBEEF; d = 8'h5A; q = 8'hA5; r = 8'h3C;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (clr_err && lat == 8) clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'd9);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        n = 16'd1; d = 8'd1; q = 8'd9; r = 8'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_n_rec", 32'(n_rec), 32'(e.n_rec));
        check("bp_abs_err", 32'(abs_err), 32'(e.abs_err));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int stray;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    n = '0; d = '0; q = '0; r = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_n_rec", 32'(n_rec), 32'd0);
    check("rst_abs_err", 32'(abs_err), 32'd0);
    check("rst_exact", 32'(exact), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_err_sum", err_sum, 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    do_txn(16'd1000, 8'd10, 8'd100, 8'd0, mk(16'd1000, 16'd0, 1'b1, 1'b0, 32'd0, 16'd1), 0, 1'b0);

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_err_sum", err_sum, 32'd0);
    check("clear_sample_cnt", 32'(sample_cnt), 32'd0);
    check("clear_keeps_n_rec", 32'(n_rec), 32'd1000);

    do_txn(16'd1000, 8'd10, 8'd99, 8'd5, mk(16'd995, 16'd5, 1'b0, 1'b0, 32'd5, 16'd1), 0, 1'b0);
    do_txn(16'd100, 8'd10, 8'd20, 8'd0, mk(16'd200, 16'd100, 1'b0, 1'b0, 32'd105, 16'd2), 0, 1'b0);
    do_txn(16'd65280, 8'd255, 8'd255, 8'd255, mk(16'd65280, 16'd0, 1'b1, 1'b0, 32'd105, 16'd3), 0, 1'b0);
    do_txn(16'd65535, 8'd7, 8'd0, 8'd0, mk(16'd0, 16'd65535, 1'b0, 1'b0, 32'd65640, 16'd4), 0, 1'b0);
    do_txn(16'd50, 8'd5, 8'd10, 8'd0, mk(16'd50, 16'd0, 1'b1, 1'b0, 32'd65640, 16'd5), 5, 1'b0);
    do_txn(16'd7, 8'd0, 8'd255, 8'd7, mk(16'd7, 16'd0, 1'b1, 1'b1, 32'd65640, 16'd5), 0, 1'b0);
    do_txn(16'd1000, 8'd10, 8'd90, 8'd0, mk(16'd900, 16'd100, 1'b0, 1'b0, 32'd0, 16'd0), 0, 1'b1);

    do_txn(16'd1000, 8'd10, 8'd80, 8'd0, mk(16'd800, 16'd200, 1'b0, 1'b0, 32'd200, 16'd1), 0, 1'b0);
    check("sat8_partial_sum", 32'(err8), 32'd200);
    do_txn(16'd100, 8'd10, 8'd20, 8'd0, mk(16'd200, 16'd100, 1'b0, 1'b0, 32'd300, 16'd2), 0, 1'b0);
    check("sat8_err_sum", 32'(err8), 32'd255);
    check("sat8_sample_cnt", 32'(cnt8), 32'd2);

    // Abort a tuple with reset in the middle of the multiply
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    n = 16'd500; d = 8'd10; q = 8'd50; r = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_err_sum", err_sum, 32'd0);
    check("abort_sample_cnt", 32'(sample_cnt), 32'd0);
    check("abort_n_rec", 32'(n_rec), 32'd0);
    check("abort_err8", 32'(err8), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_idle_in_ready", 32'(in_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("abort_no_output", 32'(stray), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
